// File: rtl/cv_cmd_dispatcher.sv
// Command-stream parser for the CV core wrappers: decodes host headers and drives the
// shared PE control bus (config words, load/store strobes, data in/out forwarding).
module cv_cmd_dispatcher #(
    parameter int unsigned NUM_PE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    input  logic        pe_idle,
    output logic [7:0]  id,
    output logic        broadcast,
    output logic        cfg,
    output logic [12:0] cfg_Iext,
    output logic [12:0] cfg_Oext,
    output logic [12:0] cfg_Hext,
    output logic [12:0] cfg_Wext,
    output logic [12:0] cfg_Iori,
    output logic [12:0] cfg_Oori,
    output logic [12:0] cfg_Hori,
    output logic [12:0] cfg_Wori,
    output logic        load_weight,
    output logic        load_input,
    output logic        store_output,
    output logic        din_valid,
    output logic [15:0] din_data,
    input  logic        dout_valid,
    output logic        dout_ready,
    input  logic [15:0] dout_data,
    output logic        busy,
    output logic        err
);

    localparam int unsigned CW = 13;
    localparam int unsigned NW = 16;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_CFG   = 4'd1;
    localparam logic [3:0] OP_LOADW = 4'd2;
    localparam logic [3:0] OP_LOADI = 4'd3;
    localparam logic [3:0] OP_STORE = 4'd4;

    typedef enum logic [2:0] {
        S_HDR, S_CFG, S_LEN, S_STRB, S_LOAD, S_STORE
    } state_t;

    state_t          state, next_state;
    logic [3:0]      op_q;
    logic [2:0]      cfg_cnt;
    logic [NW-1:0]   cnt;
    logic [CW-1:0]   shadow [0:6];

    logic [3:0]      hdr_op;
    logic            hdr_bc;
    logic [7:0]      hdr_id;
    logic            hdr_op_ok;
    logic            hdr_id_bad;

    assign hdr_op     = in_data[15:12];
    assign hdr_bc     = in_data[11];
    assign hdr_id     = in_data[7:0];
    assign hdr_op_ok  = (hdr_op <= OP_STORE);
    assign hdr_id_bad = !hdr_bc && (32'(hdr_id) >= NUM_PE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_HDR;
        else     state <= next_state;
    end

    // Next state and the zero-latency stream handshakes
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        din_valid  = 1'b0;
        din_data   = '0;
        out_valid  = 1'b0;
        out_data   = '0;
        dout_ready = 1'b0;
        case (state)
            S_HDR: begin
                in_ready = pe_idle;
                if (in_valid && pe_idle) begin
                    case (hdr_op)
                        OP_CFG:                     next_state = S_CFG;
                        OP_LOADW, OP_LOADI, OP_STORE: next_state = S_LEN;
                        default:                    next_state = S_HDR;
                    endcase
                end
            end
            S_CFG: begin
                in_ready = 1'b1;
                if (in_valid && cfg_cnt == 3'd7) next_state = S_HDR;
            end
            S_LEN: begin
                in_ready = 1'b1;
                if (in_valid) next_state = S_STRB;
            end
            S_STRB: begin
                if (cnt == '0)              next_state = S_HDR;
                else if (op_q == OP_STORE)  next_state = S_STORE;
                else                        next_state = S_LOAD;
            end
            S_LOAD: begin
                in_ready  = 1'b1;
                din_valid = in_valid;
                din_data  = in_data;
                if (in_valid && cnt == NW'(1)) next_state = S_HDR;
            end
            S_STORE: begin
                out_valid  = dout_valid;
                out_data   = dout_data;
                dout_ready = out_ready;
                if (dout_valid && out_ready && cnt == NW'(1)) next_state = S_HDR;
            end
            default: next_state = S_HDR;
        endcase
    end

    // Header latches, counters, config shadow/commit and registered strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= OP_NOP;
            id           <= '0;
            broadcast    <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
            cfg_cnt      <= '0;
            cnt          <= '0;
            cfg          <= 1'b0;
            load_weight  <= 1'b0;
            load_input   <= 1'b0;
            store_output <= 1'b0;
            for (int i = 0; i < 7; i++) shadow[i] <= '0;
            cfg_Iext <= '0; cfg_Oext <= '0; cfg_Hext <= '0; cfg_Wext <= '0;
            cfg_Iori <= '0; cfg_Oori <= '0; cfg_Hori <= '0; cfg_Wori <= '0;
        end else begin
            cfg          <= 1'b0;
            load_weight  <= 1'b0;
            load_input   <= 1'b0;
            store_output <= 1'b0;
            busy         <= (next_state != S_HDR);
            case (state)
                S_HDR: begin
                    if (in_valid && pe_idle) begin
                        if (hdr_op_ok) begin
                            op_q      <= hdr_op;
                            id        <= hdr_id;
                            broadcast <= hdr_bc;
                            if (hdr_id_bad) err <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_CFG: begin
                    if (in_valid) begin
                        cfg_cnt <= cfg_cnt + 3'd1;
                        if (cfg_cnt == 3'd7) begin
                            // Commit all eight words together so cfg_* never show a partial set
                            cfg      <= 1'b1;
                            cfg_Iext <= shadow[0];
                            cfg_Oext <= shadow[1];
                            cfg_Hext <= shadow[2];
                            cfg_Wext <= shadow[3];
                            cfg_Iori <= shadow[4];
                            cfg_Oori <= shadow[5];
                            cfg_Hori <= shadow[6];
                            cfg_Wori <= in_data[CW-1:0];
                        end else begin
                            shadow[cfg_cnt] <= in_data[CW-1:0];
                        end
                    end
                end
                S_LEN: begin
                    if (in_valid) begin
                        cnt          <= in_data;
                        load_weight  <= (op_q == OP_LOADW);
                        load_input   <= (op_q == OP_LOADI);
                        store_output <= (op_q == OP_STORE);
                    end
                end
                S_LOAD: begin
                    if (in_valid) cnt <= cnt - NW'(1);
                end
                S_STORE: begin
                    if (dout_valid && out_ready) cnt <= cnt - NW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cv_cmd_dispatcher.sv
// Directed self-checking bench for cv_cmd_dispatcher: config, loads, store, stalls,
// error detection and mid-command reset.
module tb_cv_cmd_dispatcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        pe_idle;
    logic [7:0]  id;
    logic        broadcast;
    logic        cfg;
    logic [12:0] cfg_Iext, cfg_Oext, cfg_Hext, cfg_Wext;
    logic [12:0] cfg_Iori, cfg_Oori, cfg_Hori, cfg_Wori;
    logic        load_weight, load_input, store_output;
    logic        din_valid;
    logic [15:0] din_data;
    logic        dout_valid;
    logic        dout_ready;
    logic [15:0] dout_data;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;
    int n_cfg  = 0;
    logic [15:0] din_q [$];
    logic [15:0] out_q [$];

    always #5 clk = ~clk;

    cv_cmd_dispatcher #(.NUM_PE(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .pe_idle(pe_idle), .id(id), .broadcast(broadcast), .cfg(cfg),
        .cfg_Iext(cfg_Iext), .cfg_Oext(cfg_Oext), .cfg_Hext(cfg_Hext), .cfg_Wext(cfg_Wext),
        .cfg_Iori(cfg_Iori), .cfg_Oori(cfg_Oori), .cfg_Hori(cfg_Hori), .cfg_Wori(cfg_Wori),
        .load_weight(load_weight), .load_input(load_input), .store_output(store_output),
        .din_valid(din_valid), .din_data(din_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .busy(busy), .err(err)
    );

    // Passive beat recorders, sampled mid-cycle
    always @(negedge clk) begin
        if (cfg) n_cfg++;
        if (din_valid) din_q.push_back(din_data);
        if (out_valid && out_ready) out_q.push_back(out_data);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one word for one cycle; in_ready must be high. Returns at posedge+1.
    task automatic send(input logic [15:0] w);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        chk("send_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        pe_idle = 1'b0; dout_valid = 1'b0; dout_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_id", 32'(id), 32'd0);
        chk("rst_cfg_Iext", 32'(cfg_Iext), 32'd0);
        chk("rst_in_ready_idle0", 32'(in_ready), 32'd0);
        pe_idle = 1'b1; #1;
        chk("rst_in_ready_idle1", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // 1: CFG to PE 3, words 1..8
        send(16'h1003);
        chk("cfg_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            chk("cfg_no_early_pulse", 32'(cfg), 32'd0);
            send(16'(i));
        end
        chk("cfg_pulse", 32'(cfg), 32'd1);
        chk("cfg_id", 32'(id), 32'd3);
        chk("cfg_Iext", 32'(cfg_Iext), 32'd1);
        chk("cfg_Oext", 32'(cfg_Oext), 32'd2);
        chk("cfg_Hori", 32'(cfg_Hori), 32'd7);
        chk("cfg_Wori", 32'(cfg_Wori), 32'd8);
        @(posedge clk); #1;
        chk("cfg_pulse_end", 32'(cfg), 32'd0);
        chk("cfg_pulse_count", 32'(n_cfg), 32'd1);

        // 2: broadcast LOAD_W, N=4
        send(16'h2800);
        chk("lw_broadcast", 32'(broadcast), 32'd1);
        chk("lw_id", 32'(id), 32'd0);
        send(16'd4);
        chk("lw_strobe", 32'(load_weight), 32'd1);
        chk("lw_in_ready_strb", 32'(in_ready), 32'd0);
        chk("lw_no_din_before", 32'(din_q.size()), 32'd0);
        @(posedge clk); #1;
        chk("lw_strobe_end", 32'(load_weight), 32'd0);
        for (int i = 0; i < 4; i++) send(16'hA0 + 16'(i));
        chk("lw_busy_after", 32'(busy), 32'd0);
        chk("lw_din_n", 32'(din_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < din_q.size(); i++)
            chk("lw_din_data", 32'(din_q[i]), 32'hA0 + 32'(i));
        din_q.delete();

        // 3: STORE from PE 2, N=3, out_ready 1,0,1
        send(16'h4002);
        send(16'd3);
        chk("st_strobe", 32'(store_output), 32'd1);
        chk("st_id", 32'(id), 32'd2);
        @(posedge clk); #1;
        dout_valid = 1'b1; dout_data = 16'hB0; out_ready = 1'b1;
        @(negedge clk);
        chk("st_out_valid", 32'(out_valid), 32'd1);
        chk("st_out_data0", 32'(out_data), 32'hB0);
        chk("st_dout_ready1", 32'(dout_ready), 32'd1);
        chk("st_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        dout_data = 16'hB1; out_ready = 1'b0;
        @(negedge clk);
        chk("st_dout_ready0", 32'(dout_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        dout_data = 16'hB2;
        @(posedge clk); #1;
        chk("st_out_valid_after", 32'(out_valid), 32'd0);
        chk("st_dout_ready_after", 32'(dout_ready), 32'd0);
        chk("st_busy_after", 32'(busy), 32'd0);
        dout_valid = 1'b0; out_ready = 1'b0;
        chk("st_beats", 32'(out_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < out_q.size(); i++)
            chk("st_out_data", 32'(out_q[i]), 32'hB0 + 32'(i));

        // 4: LOAD_I with N=0, then a header stalled by pe_idle=0
        send(16'h3000);
        send(16'd0);
        chk("li_strobe", 32'(load_input), 32'd1);
        @(posedge clk); #1;
        chk("li_strobe_end", 32'(load_input), 32'd0);
        chk("li_busy", 32'(busy), 32'd0);
        chk("li_no_din", 32'(din_q.size()), 32'd0);
        pe_idle = 1'b0; in_valid = 1'b1; in_data = 16'h1005;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        chk("stall_busy", 32'(busy), 32'd0);
        chk("stall_id", 32'(id), 32'd0);
        pe_idle = 1'b1;
        @(negedge clk);
        chk("stall_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("stall_accept_busy", 32'(busy), 32'd1);
        chk("stall_accept_id", 32'(id), 32'd5);
        for (int i = 1; i <= 8; i++) send(16'h10 + 16'(i));
        chk("cfg2_Hext", 32'(cfg_Hext), 32'h13);
        chk("cfg2_Wori", 32'(cfg_Wori), 32'h18);
        @(posedge clk); #1;
        chk("cfg2_pulse_count", 32'(n_cfg), 32'd2);

        // 5a: unicast id 0x20 out of range still executes
        chk("err_clear_before", 32'(err), 32'd0);
        send(16'h2020);
        chk("idbad_err", 32'(err), 32'd1);
        chk("idbad_id", 32'(id), 32'h20);
        send(16'd1);
        chk("idbad_strobe", 32'(load_weight), 32'd1);
        @(posedge clk); #1;
        send(16'hC0);
        chk("idbad_busy", 32'(busy), 32'd0);
        chk("idbad_din_n", 32'(din_q.size()), 32'd1);
        if (din_q.size() > 0) chk("idbad_din", 32'(din_q[0]), 32'hC0);
        din_q.delete();
        do_reset();
        chk("reset_err", 32'(err), 32'd0);

        // 5b: illegal op 7 consumed as NOP, err sticky
        send(16'h7000);
        chk("op7_busy", 32'(busy), 32'd0);
        chk("op7_err", 32'(err), 32'd1);
        chk("op7_id_unlatched", 32'(id), 32'd0);
        repeat (2) @(posedge clk); #1;
        send(16'h0001);
        chk("op7_err_sticky", 32'(err), 32'd1);
        chk("nop_id", 32'(id), 32'd1);
        chk("nop_busy", 32'(busy), 32'd0);

        // 6: reset after 5 of 8 CFG words
        send(16'h1009);
        for (int i = 1; i <= 5; i++) send(16'(i));
        do_reset();
        chk("mid_cfg", 32'(cfg), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_id", 32'(id), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_cfg_Iext", 32'(cfg_Iext), 32'd0);
        @(posedge clk); #1;
        chk("mid_pulse_count", 32'(n_cfg), 32'd2);
        send(16'h1004);
        for (int i = 1; i <= 8; i++) send(16'h20 + 16'(i));
        chk("cfg3_pulse", 32'(cfg), 32'd1);
        chk("cfg3_id", 32'(id), 32'd4);
        chk("cfg3_Iext", 32'(cfg_Iext), 32'h21);
        chk("cfg3_Oext", 32'(cfg_Oext), 32'h22);
        chk("cfg3_Wori", 32'(cfg_Wori), 32'h28);
        @(posedge clk); #1;
        chk("cfg3_pulse_count", 32'(n_cfg), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
